// File: rtl/gray_ro_serializer.sv
// Purpose     : framed single-pin readout of N_CH channel bits: a sync word, then one slot per
//               eligible and unmasked channel, with channel k decimated to every 2^k-th frame.
// Latency     : en sampled high in IDLE at edge t puts the first sync bit on out in cycle t+1.
// Backpressure: none; one bit per clk_ext, and back-to-back frames leave no gap while en stays high.
// Ports       : clk_ext/rstb clock and async active-low reset; en frame enable (sampled at frame
//               boundaries); ch_in/ch_mask snapshotted at frame start; out/out_valid/frame_start/
//               ch_idx registered serial stream with Gray-coded channel index (0 outside DATA).
// Option      : define GRAY_RO_PARITY_EN to append an even-parity bit over the frame's data bits.
module gray_ro_serializer #(
  parameter int                N_CH      = 8,
  parameter int                SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 4'b1011,
  localparam int               CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk_ext,
  input  logic            rstb,
  input  logic            en,
  input  logic [N_CH-1:0] ch_in,
  input  logic [N_CH-1:0] ch_mask,
  output logic            out,
  output logic            out_valid,
  output logic            frame_start,
  output logic [CW-1:0]   ch_idx
);

  localparam int FW = N_CH - 1;
  localparam int BW = (SYNC_W > 1) ? $clog2(SYNC_W) : 1;

`ifdef GRAY_RO_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_PAR} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA} state_t;
`endif

  state_t          state_q, state_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [N_CH-1:0] snap_q, snap_d;
  logic [N_CH-1:0] msk_q, msk_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            frame_start_q, frame_start_d;
  logic [CW-1:0]   ch_idx_q, ch_idx_d;

  logic            eof;
  logic            start;
  logic            tail;
  logic [CW:0]     hit;
  logic [BW-1:0]   sidx;

  // Lowest set bit of m at or above index 'from'; MSB of the result flags a hit.
  function automatic logic [CW:0] find_from(input logic [N_CH-1:0] m, input int from);
    logic [CW:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = {1'b1, CW'(i)};
    end
    return r;
  endfunction

  // Channel k is eligible when the low k bits of the frame counter are all zero.
  function automatic logic [N_CH-1:0] elig_of(input logic [FW-1:0] fc);
    logic [N_CH-1:0] e;
    e[0] = 1'b1;
    for (int k = 1; k < N_CH; k++) e[k] = e[k-1] & ~fc[k-1];
    return e;
  endfunction

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    ch_d    = ch_q;
    snap_d  = snap_q;
    msk_d   = msk_q;
    fcnt_d  = fcnt_q;
    eof     = 1'b0;
    start   = 1'b0;
    tail    = 1'b0;
    hit     = '0;

    case (state_q)
      ST_IDLE: begin
        if (en) start = 1'b1;
      end
      ST_SYNC: begin
        if (bit_q == BW'(SYNC_W - 1)) begin
          hit = find_from(msk_q, 0);
          if (hit[CW]) begin
            state_d = ST_DATA;
            ch_d    = hit[CW-1:0];
          end else begin
            tail = 1'b1;
          end
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      ST_DATA: begin
        hit = find_from(msk_q, int'(ch_q) + 1);
        if (hit[CW]) ch_d = hit[CW-1:0];
        else         tail = 1'b1;
      end
`ifdef GRAY_RO_PARITY_EN
      ST_PAR: begin
        eof = 1'b1;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Last sync or data slot done: parity slot if built in, otherwise frame ends here.
    if (tail) begin
`ifdef GRAY_RO_PARITY_EN
      state_d = ST_PAR;
`else
      eof = 1'b1;
`endif
    end

    if (eof) begin
      fcnt_d  = fcnt_q + FW'(1);
      state_d = ST_IDLE;
      if (en) start = 1'b1;
    end

    // New frame: snapshot uses the counter value of the frame about to start.
    if (start) begin
      state_d = ST_SYNC;
      bit_d   = '0;
      snap_d  = ch_in;
      msk_d   = ch_mask & elig_of(fcnt_d);
    end

    // Outputs are derived from the next state so they register in step with it.
    sidx          = BW'(SYNC_W - 1) - bit_d;
    out_d         = 1'b0;
    out_valid_d   = (state_d != ST_IDLE);
    frame_start_d = (state_d == ST_SYNC) && (bit_d == '0);
    ch_idx_d      = '0;
    case (state_d)
      ST_SYNC: out_d = SYNC_WORD[sidx];
      ST_DATA: begin
        out_d    = snap_d[ch_d];
        ch_idx_d = ch_d ^ (ch_d >> 1);
      end
`ifdef GRAY_RO_PARITY_EN
      ST_PAR:  out_d = ^(snap_d & msk_d);
`endif
      default: out_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_ext or negedge rstb) begin
    if (!rstb) begin
      state_q       <= ST_IDLE;
      bit_q         <= '0;
      ch_q          <= '0;
      snap_q        <= '0;
      msk_q         <= '0;
      fcnt_q        <= '0;
      out_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      ch_idx_q      <= '0;
    end else begin
      state_q       <= state_d;
      bit_q         <= bit_d;
      ch_q          <= ch_d;
      snap_q        <= snap_d;
      msk_q         <= msk_d;
      fcnt_q        <= fcnt_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      ch_idx_q      <= ch_idx_d;
    end
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign ch_idx      = ch_idx_q;

endmodule

// File: tb/tb_gray_ro_serializer.sv
// Purpose     : directed self-checking bench for gray_ro_serializer (N_CH=8, SYNC_WORD=1011).
// Latency     : outputs sampled on the falling edge, half a cycle after they register.
// Backpressure: not applicable; the bench consumes every serial bit.
module tb_gray_ro_serializer;

`ifdef GRAY_RO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk_ext;
  logic       rstb;
  logic       en;
  logic [7:0] ch_in;
  logic [7:0] ch_mask;
  logic       out;
  logic       out_valid;
  logic       frame_start;
  logic [2:0] ch_idx;

  int vectors;
  int miscompares;

  logic [63:0]  m_bits;
  logic [127:0] m_idx;
  logic [63:0]  m_fs;
  int           m_len;
  logic         m_end_fs;

  gray_ro_serializer #(.N_CH(8), .SYNC_W(4), .SYNC_WORD(4'b1011)) dut (
    .clk_ext     (clk_ext),
    .rstb        (rstb),
    .en          (en),
    .ch_in       (ch_in),
    .ch_mask     (ch_mask),
    .out         (out),
    .out_valid   (out_valid),
    .frame_start (frame_start),
    .ch_idx      (ch_idx)
  );

  initial clk_ext = 1'b0;
  always #5 clk_ext = ~clk_ext;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bit string with the parity bit appended when parity is built in.
  function automatic logic [63:0] wpar(input logic [63:0] b, input logic p);
    return PAR ? {b[62:0], p} : b;
  endfunction

  function automatic int tz(input int f);
    int r = 0;
    while (r < 7 && f[r] == 1'b0) r++;
    return r;
  endfunction

  // Wait (bounded) for a falling edge where frame_start is high.
  task automatic sync_fs(input string tag);
    int n = 0;
    while (!frame_start && n < 300) begin
      @(negedge clk_ext);
      n++;
    end
    chk(tag, frame_start, 1'b1);
  endtask

  // Records one frame starting at the current falling edge; drops en after sample drop_at.
  task automatic measure(input int drop_at);
    m_len  = 0;
    m_bits = '0;
    m_idx  = '0;
    m_fs   = '0;
    do begin
      m_bits = {m_bits[62:0], out};
      m_idx  = {m_idx[124:0], ch_idx};
      m_fs   = {m_fs[62:0], frame_start};
      m_len++;
      if (m_len == drop_at) en = 1'b0;
      @(negedge clk_ext);
    end while (out_valid && !frame_start && m_len < 40);
    m_end_fs = frame_start;
  endtask

  task automatic do_reset(input logic [7:0] din, input logic [7:0] dmsk);
    @(negedge clk_ext);
    rstb    = 1'b0;
    en      = 1'b0;
    ch_in   = din;
    ch_mask = dmsk;
    @(negedge clk_ext);
    @(negedge clk_ext);
    rstb = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstb    = 1'b0;
    en      = 1'b0;
    ch_in   = 8'hA5;
    ch_mask = 8'hFF;

    // Reset state and idle behaviour.
    @(negedge clk_ext);
    @(negedge clk_ext);
    chk("rst_outs", {out, out_valid, frame_start, ch_idx}, 6'b0);
    rstb = 1'b1;
    @(negedge clk_ext);
    @(negedge clk_ext);
    chk("idle_outs", {out, out_valid}, 2'b00);
    en = 1'b1;
    @(negedge clk_ext);
    chk("start_latency", {frame_start, out_valid}, 2'b11);

    // Frame 0: all channels.
    measure(0);
    chk("f0_len", m_len, 12 + PAR);
    chk("f0_bits", m_bits, wpar(64'hBA5, 1'b0));
    chk("f0_idx", m_idx, PAR ? (128'o000001326754 << 3) : 128'o000001326754);
    chk("f0_fs", m_fs, 64'h1 << (11 + PAR));
    chk("f0_b2b", m_end_fs, 1'b1);

    // Decimation frames 1..4.
    measure(0);
    chk("f1_len", m_len, 5 + PAR);
    chk("f1_bits", m_bits, wpar(64'h17, 1'b1));
    measure(0);
    chk("f2_len", m_len, 6 + PAR);
    chk("f2_bits", m_bits, wpar(64'h2E, 1'b1));
    measure(0);
    chk("f3_len", m_len, 5 + PAR);
    chk("f3_bits", m_bits, wpar(64'h17, 1'b1));
    measure(0);
    chk("f4_len", m_len, 7 + PAR);
    chk("f4_bits", m_bits, wpar(64'h5D, 1'b0));

    // Frames 5..127: slots = 1 + trailing zeros of the frame number.
    for (int f = 5; f < 128; f++) begin
      measure(0);
      chk($sformatf("f%0d_len", f), m_len, 5 + tz(f) + PAR);
    end
    // Frame 128: counter wrapped to 0, ch7 back.
    measure(0);
    chk("f128_len", m_len, 12 + PAR);
    chk("f128_bits", m_bits, wpar(64'hBA5, 1'b0));

    // Mask all zero: sync-only frames, back to back.
    do_reset(8'hA5, 8'h00);
    en = 1'b1;
    sync_fs("m0_fs");
    measure(0);
    chk("m0_len", m_len, 4 + PAR);
    chk("m0_bits", m_bits, wpar(64'hB, 1'b0));
    chk("m0_b2b", m_end_fs, 1'b1);
    measure(0);
    chk("m1_len", m_len, 4 + PAR);
    chk("m1_b2b", m_end_fs, 1'b1);

    // Snapshot: ch_in changes during sync have no effect on this frame.
    do_reset(8'hFF, 8'hFF);
    en = 1'b1;
    sync_fs("s0_fs");
    ch_in = 8'h00;
    measure(0);
    chk("s0_len", m_len, 12 + PAR);
    chk("s0_bits", m_bits, wpar(64'hBFF, 1'b0));
    measure(0);
    chk("s1_bits", m_bits, wpar(64'h16, 1'b0));

    // en dropped in the ch3 slot: frame completes, then idle; re-enable after 3 cycles.
    do_reset(8'hA5, 8'hFF);
    en = 1'b1;
    sync_fs("e0_fs");
    measure(8);
    chk("e0_len", m_len, 12 + PAR);
    chk("e0_bits", m_bits, wpar(64'hBA5, 1'b0));
    chk("e0_end_idle", {m_end_fs, out_valid}, 2'b00);
    @(negedge clk_ext);
    @(negedge clk_ext);
    chk("e_idle3", out_valid, 1'b0);
    en = 1'b1;
    @(negedge clk_ext);
    chk("e1_fs_latency", frame_start, 1'b1);
    measure(0);
    chk("e1_len", m_len, 5 + PAR);
    chk("e1_bits", m_bits, wpar(64'h17, 1'b1));

    // Async reset in the ch2 slot of frame 4.
    do_reset(8'hA5, 8'hFF);
    en = 1'b1;
    sync_fs("r_fs");
    for (int f = 0; f < 4; f++) measure(0);
    repeat (6) @(negedge clk_ext);
    chk("r_pre", {out, out_valid, ch_idx}, 5'b1_1_011);
    #2 rstb = 1'b0;
    #1 chk("r_async", {out, out_valid, ch_idx}, 5'b0);
    @(negedge clk_ext);
    rstb = 1'b1;
    @(negedge clk_ext);
    chk("r_restart_fs", frame_start, 1'b1);
    measure(0);
    chk("r_len", m_len, 12 + PAR);
    chk("r_bits", m_bits, wpar(64'hBA5, 1'b0));

`ifdef GRAY_RO_PARITY_EN
    // Parity over the data actually sent.
    do_reset(8'h07, 8'hFF);
    en = 1'b1;
    sync_fs("p0_fs");
    measure(0);
    chk("p0_bits", m_bits, 64'h17C1);
    measure(0);
    chk("p1_bits", m_bits, 64'h2F);
`endif

    en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_ro_serializer.md
# gray_ro_serializer

Parametrised next-generation readout serializer for the cochlea channel bank. It snapshots N_CH channel bits at the start of each frame and emits a framed serial stream on a single output pin: a sync word, then one slot per eligible channel. Channel k is decimated to every 2^k-th frame, so the octave rate division is built into the frame schedule rather than taken from a divided-clock tree. It sits between the channel bank outputs and the chip readout pad, replacing the fixed 8-channel token-driven out bus.

## Interface
- N_CH, 8, number of channels (2..16)
- SYNC_W, 4, sync word length in bits (1..8)
- SYNC_WORD, 4'b1011, sync pattern, sent MSB first
- clk_ext  input  1  readout clock; all logic on the rising edge
- rstb  input  1  asynchronous active-low reset
- en  input  1  frame enable; sampled only at frame boundaries
- ch_in  input  N_CH  channel sample bits
- ch_mask  input  N_CH  per-channel enable; a 0 bit drops that channel's slot
- out  output  1  serial data, registered
- out_valid  output  1  high whenever out carries a sync, data or parity bit
- frame_start  output  1  high with the first sync bit of each frame
- ch_idx  output  clog2(N_CH)  Gray-coded index of the channel currently on out; 0 outside DATA

## Operation
- FSM states: IDLE, SYNC, DATA, PAR (PAR exists only with the macro).
- IDLE: if en=1, load the snapshot registers snap←ch_in and msk←ch_mask & elig, then go to SYNC with bit counter 0.
- elig[k]=1 when the low k bits of frame_cnt are zero, so ch0 is eligible in every frame and ch k in every 2^k-th frame.
- SYNC: out=SYNC_WORD[SYNC_W-1-i] for i=0..SYNC_W-1. After the last bit, go to DATA at the lowest set bit of msk. If msk=0, skip DATA and go to PAR, or to end-of-frame without the macro.
- DATA: out=snap[k], ch_idx=k^(k>>1). Advance to the next set bit of msk in ascending order; after the highest set bit, go to end-of-frame.
- End-of-frame: frame_cnt increments by 1 (width N_CH-1, wraps all-ones→0). If en=1, go directly into SYNC with a new snapshot and no idle cycle; else go to IDLE.
- ch_in and ch_mask changes mid-frame have no effect until the next snapshot.
- en deasserted mid-frame: the current frame completes, then IDLE.
- frame_cnt is not cleared by en; only rstb clears it.

## Timing
- Reset (async assert, sync-safe deassert assumed upstream): state=IDLE, out=0, out_valid=0, frame_start=0, ch_idx=0, frame_cnt=0, snap=0, msk=0.
- Reset mid-frame aborts the frame immediately; no partial frame resumes after reset.
- Latency: en sampled high in IDLE at edge t produces the first sync bit with frame_start=1 and out_valid=1 during cycle t+1.
- Frame length = SYNC_W + popcount(msk) (+1 with parity). Back-to-back frames leave no gap in out_valid.
- out, out_valid, frame_start and ch_idx all change only on rising clk_ext and are mutually aligned.
- In IDLE, out=0 and out_valid=0.

## Configuration
- GRAY_RO_PARITY_EN defined:
  - a PAR state follows DATA, or follows SYNC when msk=0;
  - out = even parity (XOR) of the data bits sent in this frame; 0 when there are no data bits;
  - out_valid=1 and ch_idx=0 during PAR.
- Undefined: no PAR state; frames end after the last data slot (or after SYNC if msk=0).

## Test plan
- Reset check, N_CH=8, SYNC_WORD=1011, ch_mask=FF, ch_in=A5, en held high from reset release: frame 0 → out 1,0,1,1 then 1,0,1,0,0,1,0,1 (ch0..ch7); ch_idx 0,1,3,2,6,7,5,4; frame_start only on the first bit; 12 bits without parity, 13 with parity and parity bit 0.
- Decimation, same setup: frames 1,2,3,4 carry 1,2,1,3 data slots respectively (ch0 / ch0,1 / ch0 / ch0,1,2); ch7 reappears only at frame 128 after frame_cnt wraps 127→0.
- Mask and snapshot: ch_mask=00 → frames are 4 sync bits only, back-to-back. Toggling ch_in=FF→00 during SYNC of frame 0 → frame 0 data still reflects the snapshot taken at frame start.
- en dropped during the DATA slot of ch3 in frame 0: ch4..ch7 still sent, then out_valid=0; reasserting en 3 cycles later → frame_start exactly 1 cycle after en is sampled, with frame_cnt=1.
- rstb pulsed low during DATA: out, out_valid and ch_idx go to 0 asynchronously, without waiting for a clock edge. After release with en=1, the next frame carries all channels (frame_cnt=0).
- Parity (macro on): ch_in=07, ch_mask=FF, frame 0 → parity bit 1. Frame 1, with only ch0=1 sent → parity bit 1.
